// File: rtl/dang9_pkg.sv
// Shared constants and types for the three-ball collision scanner.
package dang9_pkg;

  localparam int unsigned BALL_R       = 8;
  localparam int unsigned CTR_TOL      = 4;
  localparam int unsigned COLL_DIST_SQ = (2 * BALL_R) * (2 * BALL_R);

  // Enum value doubles as the bit index into the contact vector.
  typedef enum logic [1:0] {
    P12 = 2'd0,
    P13 = 2'd1,
    P23 = 2'd2
  } pair_e;

  typedef enum logic [2:0] {
    IDLE,
    DIFF,
    SQ,
    CMP,
    REPORT
  } state_e;

  typedef struct packed {
    logic lx;
    logic cx;
    logic rx;
    logic ty;
    logic cy;
    logic by;
  } zone_t;

  // Ball membership of a pair, bit0 = ball 1.
  function automatic logic [2:0] pair_balls(pair_e pair);
    case (pair)
      P12:     return 3'b011;
      P13:     return 3'b101;
      P23:     return 3'b110;
      default: return 3'b000;
    endcase
  endfunction

  function automatic pair_e next_pair(pair_e pair);
    case (pair)
      P12:     return P13;
      P13:     return P23;
      default: return P12;
    endcase
  endfunction

endpackage

// File: rtl/ball_collision_detect_if.sv
// Scan request, ball positions and collision report bundle.
interface ball_collision_detect_if #(
  parameter int unsigned XW = 10,
  parameter int unsigned YW = 10
);
  logic          scan_start;
  logic [XW-1:0] x1;
  logic [XW-1:0] x2;
  logic [XW-1:0] x3;
  logic [YW-1:0] y1;
  logic [YW-1:0] y2;
  logic [YW-1:0] y3;
  logic          busy;
  logic          coll_valid;
  logic          ball1_flag;
  logic          ball2_flag;
  logic          ball3_flag;
  logic          lx_flag;
  logic          cx_flag;
  logic          rx_flag;
  logic          ty_flag;
  logic          cy_flag;
  logic          by_flag;
  logic [2:0]    contact;

  modport master (
    output scan_start, x1, x2, x3, y1, y2, y3,
    input  busy, coll_valid, ball1_flag, ball2_flag, ball3_flag,
    input  lx_flag, cx_flag, rx_flag, ty_flag, cy_flag, by_flag, contact
  );

  modport slave (
    input  scan_start, x1, x2, x3, y1, y2, y3,
    output busy, coll_valid, ball1_flag, ball2_flag, ball3_flag,
    output lx_flag, cx_flag, rx_flag, ty_flag, cy_flag, by_flag, contact
  );
endinterface

// File: rtl/ball_pair_geom.sv
// Two-stage pair geometry: registered signed deltas, then registered squares;
// distance compare and zone classification are combinational off those registers.
module ball_pair_geom
  import dang9_pkg::*;
#(
  parameter int unsigned XW = 10,
  parameter int unsigned YW = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_diff,
  input  logic          load_sq,
  input  logic [XW-1:0] xa,
  input  logic [XW-1:0] xb,
  input  logic [YW-1:0] ya,
  input  logic [YW-1:0] yb,
  output logic          coll,
  output zone_t         zone
);

  localparam int unsigned SqXW = 2 * (XW + 1);
  localparam int unsigned SqYW = 2 * (YW + 1);
  localparam int unsigned SumW = ((SqXW > SqYW) ? SqXW : SqYW) + 1;
  localparam int signed   Tol  = int'(CTR_TOL);

  logic signed [XW:0]   dx_d, dx_q;
  logic signed [YW:0]   dy_d, dy_q;
  logic        [XW:0]   ax;
  logic        [YW:0]   ay;
  logic        [SqXW-1:0] sqx_q;
  logic        [SqYW-1:0] sqy_q;
  logic        [SumW-1:0] dist_sq;
  int                     dx_i, dy_i;

  always_comb begin
    dx_d = $signed({1'b0, xa}) - $signed({1'b0, xb});
    dy_d = $signed({1'b0, ya}) - $signed({1'b0, yb});
    // Squaring the magnitude keeps the multiplier unsigned.
    ax   = dx_q[XW] ? $unsigned(-dx_q) : $unsigned(dx_q);
    ay   = dy_q[YW] ? $unsigned(-dy_q) : $unsigned(dy_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dx_q  <= '0;
      dy_q  <= '0;
      sqx_q <= '0;
      sqy_q <= '0;
    end else begin
      if (load_diff) begin
        dx_q <= dx_d;
        dy_q <= dy_d;
      end
      if (load_sq) begin
        sqx_q <= SqXW'(ax) * SqXW'(ax);
        sqy_q <= SqYW'(ay) * SqYW'(ay);
      end
    end
  end

  always_comb begin
    dist_sq = SumW'(sqx_q) + SumW'(sqy_q);
    coll    = dist_sq <= SumW'(COLL_DIST_SQ);
    dx_i    = int'(dx_q);
    dy_i    = int'(dy_q);
    zone.lx = dx_i < -Tol;
    zone.rx = dx_i > Tol;
    zone.cx = !zone.lx && !zone.rx;
    zone.ty = dy_i < -Tol;
    zone.by = dy_i > Tol;
    zone.cy = !zone.ty && !zone.by;
  end

endmodule

// File: rtl/ball_collision_detect.sv
// Per-frame pair scanner: snapshots three ball positions, walks pairs 1-2, 1-3, 2-3
// through a shared geometry pipeline and pulses one report per newly made contact.
module ball_collision_detect
  import dang9_pkg::*;
#(
  parameter int unsigned XW = 10,
  parameter int unsigned YW = 10
) (
  input logic                    clk,
  input logic                    rst,
  ball_collision_detect_if.slave bus
);

  state_e        state_q, state_d;
  pair_e         pair_q;
  logic          busy, snap_en, load_diff, load_sq, cmp_en, report_en;

  logic [XW-1:0] xs_q [3];
  logic [YW-1:0] ys_q [3];
  logic [XW-1:0] xa, xb;
  logic [YW-1:0] ya, yb;
  logic          geom_coll;
  zone_t         geom_zone;

  logic [2:0]    contact_q, contact_d;
  logic          found_q, found_d;
  pair_e         rpt_pair_q, rpt_pair_d;
  zone_t         rpt_zone_q, rpt_zone_d;
  logic          coll_valid_q;
  logic [2:0]    balls_q;
  zone_t         zone_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.scan_start) state_d = DIFF;
      DIFF:    state_d = SQ;
      SQ:      state_d = CMP;
      CMP:     state_d = (pair_q == P23) ? REPORT : DIFF;
      REPORT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy      = state_q != IDLE;
    snap_en   = (state_q == IDLE) && bus.scan_start;
    load_diff = state_q == DIFF;
    load_sq   = state_q == SQ;
    cmp_en    = state_q == CMP;
    report_en = state_q == REPORT;
  end

  always_ff @(posedge clk) begin
    if (snap_en) begin
      xs_q[0] <= bus.x1;
      xs_q[1] <= bus.x2;
      xs_q[2] <= bus.x3;
      ys_q[0] <= bus.y1;
      ys_q[1] <= bus.y2;
      ys_q[2] <= bus.y3;
    end
  end

  always_comb begin
    xa = xs_q[0];
    ya = ys_q[0];
    xb = xs_q[1];
    yb = ys_q[1];
    case (pair_q)
      P13: begin
        xb = xs_q[2];
        yb = ys_q[2];
      end
      P23: begin
        xa = xs_q[1];
        ya = ys_q[1];
        xb = xs_q[2];
        yb = ys_q[2];
      end
      default: ;
    endcase
  end

  ball_pair_geom #(
    .XW(XW),
    .YW(YW)
  ) u_geom (
    .clk       (clk),
    .rst       (rst),
    .load_diff (load_diff),
    .load_sq   (load_sq),
    .xa        (xa),
    .xb        (xb),
    .ya        (ya),
    .yb        (yb),
    .coll      (geom_coll),
    .zone      (geom_zone)
  );

  // Separation re-arms a pair; only the first new contact of a scan is latched.
  always_comb begin
    contact_d  = contact_q;
    found_d    = found_q;
    rpt_pair_d = rpt_pair_q;
    rpt_zone_d = rpt_zone_q;
    if (snap_en) begin
      found_d = 1'b0;
    end
    if (cmp_en) begin
      if (!geom_coll) begin
        contact_d[pair_q] = 1'b0;
      end else if (!contact_q[pair_q] && !found_q) begin
        contact_d[pair_q] = 1'b1;
        found_d           = 1'b1;
        rpt_pair_d        = pair_q;
        rpt_zone_d        = geom_zone;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pair_q       <= P12;
      contact_q    <= '0;
      found_q      <= 1'b0;
      rpt_pair_q   <= P12;
      rpt_zone_q   <= zone_t'('0);
      coll_valid_q <= 1'b0;
      balls_q      <= '0;
      zone_q       <= zone_t'('0);
    end else begin
      contact_q    <= contact_d;
      found_q      <= found_d;
      rpt_pair_q   <= rpt_pair_d;
      rpt_zone_q   <= rpt_zone_d;
      if (snap_en) begin
        pair_q <= P12;
      end else if (cmp_en) begin
        pair_q <= next_pair(pair_q);
      end
      coll_valid_q <= report_en && found_q;
      balls_q      <= (report_en && found_q) ? pair_balls(rpt_pair_q) : 3'b000;
      zone_q       <= (report_en && found_q) ? rpt_zone_q : zone_t'('0);
    end
  end

  assign bus.busy       = busy;
  assign bus.coll_valid = coll_valid_q;
  assign bus.ball1_flag = balls_q[0];
  assign bus.ball2_flag = balls_q[1];
  assign bus.ball3_flag = balls_q[2];
  assign bus.lx_flag    = zone_q.lx;
  assign bus.cx_flag    = zone_q.cx;
  assign bus.rx_flag    = zone_q.rx;
  assign bus.ty_flag    = zone_q.ty;
  assign bus.cy_flag    = zone_q.cy;
  assign bus.by_flag    = zone_q.by;
  assign bus.contact    = contact_q;

endmodule

// File: tb/tb_ball_collision_detect.sv
// Scoreboard bench: a geometry model predicts each scan's report, the observed scan is
// collected cycle by cycle and compared against the queued prediction.
module tb_ball_collision_detect;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ball_collision_detect_if #(.XW(10), .YW(10)) bus ();

  ball_collision_detect #(
    .XW(10),
    .YW(10)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [3:0] busy_cyc;
    logic [3:0] lat;
    logic [1:0] n_valid;
    logic       stray;
    logic [8:0] flags;
    logic [2:0] contact;
  } res_t;

  res_t       sb_q[$];
  int         px[3];
  int         py[3];
  logic [2:0] m_contact;
  int         n_pass;
  int         n_total;

  function automatic logic [8:0] flags_now();
    return {bus.ball1_flag, bus.ball2_flag, bus.ball3_flag, bus.lx_flag, bus.cx_flag,
            bus.rx_flag, bus.ty_flag, bus.cy_flag, bus.by_flag};
  endfunction

  task automatic set_pos(input int p[6]);
    for (int i = 0; i < 3; i++) begin
      px[i] = p[2*i];
      py[i] = p[2*i+1];
    end
    bus.x1 = 10'(p[0]);
    bus.y1 = 10'(p[1]);
    bus.x2 = 10'(p[2]);
    bus.y2 = 10'(p[3]);
    bus.x3 = 10'(p[4]);
    bus.y3 = 10'(p[5]);
  endtask

  // Model: radius-8 balls collide at squared distance <= 256, centre tolerance 4.
  task automatic push_expected();
    res_t e;
    int   pa[3];
    int   pb[3];
    bit   found;
    pa = '{0, 0, 1};
    pb = '{1, 2, 2};
    found = 1'b0;
    e = '0;
    e.busy_cyc = 4'd10;
    for (int p = 0; p < 3; p++) begin
      int dx;
      int dy;
      dx = px[pa[p]] - px[pb[p]];
      dy = py[pa[p]] - py[pb[p]];
      if (dx * dx + dy * dy > 256) begin
        m_contact[p] = 1'b0;
      end else if (!m_contact[p] && !found) begin
        found = 1'b1;
        m_contact[p] = 1'b1;
        e.lat = 4'd11;
        e.n_valid = 2'd1;
        e.flags[8-pa[p]] = 1'b1;
        e.flags[8-pb[p]] = 1'b1;
        e.flags[5] = dx < -4;
        e.flags[4] = dx >= -4 && dx <= 4;
        e.flags[3] = dx > 4;
        e.flags[2] = dy < -4;
        e.flags[1] = dy >= -4 && dy <= 4;
        e.flags[0] = dy > 4;
      end
    end
    e.contact = m_contact;
    sb_q.push_back(e);
  endtask

  // Pulses scan_start, then observes 14 cycles; optional extra start / reset at cycle N.
  task automatic run_scan(input int extra_at, input int rst_at, output res_t o);
    o = '0;
    @(negedge clk);
    bus.scan_start = 1'b1;
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      if (bus.busy === 1'b1) o.busy_cyc = o.busy_cyc + 4'd1;
      if (bus.coll_valid === 1'b1) begin
        if (o.n_valid == 2'd0) o.lat = 4'(c);
        if (o.n_valid != 2'd3) o.n_valid = o.n_valid + 2'd1;
        o.flags = flags_now();
      end else if (flags_now() !== 9'd0) begin
        o.stray = 1'b1;
      end
      bus.scan_start = (c == extra_at);
      rst = (c == rst_at);
    end
    o.contact = bus.contact;
  endtask

  task automatic test_reset();
    n_total++;
    if (bus.busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", bus.busy);
    else n_pass++;
    n_total++;
    if (bus.coll_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", bus.coll_valid);
    else n_pass++;
    n_total++;
    if (bus.contact !== 3'b000) $display("FAIL reset_contact: got %b want 000", bus.contact);
    else n_pass++;
    n_total++;
    if (flags_now() !== 9'd0) $display("FAIL reset_flags: got %b want 0", flags_now());
    else n_pass++;
  endtask

  task automatic test_no_collision();
    res_t o, e;
    int   p[6];
    p = '{100, 100, 300, 100, 500, 100};
    set_pos(p);
    push_expected();
    run_scan(0, 0, o);
    e = sb_q.pop_front();
    n_total++;
    if (o !== e) $display("FAIL no_collision: got %h want %h", o, e);
    else n_pass++;
  endtask

  task automatic test_single_pair();
    res_t o, e;
    int   tbl[4][6];
    tbl = '{'{100, 100, 110, 100, 900, 900}, '{100, 100, 110, 100, 900, 900},
            '{100, 100, 200, 100, 900, 900}, '{100, 100, 110, 100, 900, 900}};
    for (int i = 0; i < 4; i++) begin
      set_pos(tbl[i]);
      push_expected();
      run_scan(0, 0, o);
      e = sb_q.pop_front();
      n_total++;
      if (o !== e) $display("FAIL single_pair[%0d]: got %h want %h", i, o, e);
      else n_pass++;
    end
  endtask

  task automatic test_multi_contact();
    res_t o, e;
    int   tbl[5][6];
    tbl = '{'{100, 100, 400, 400, 700, 700}, '{100, 100, 100, 110, 90, 100},
            '{100, 100, 100, 110, 90, 100}, '{100, 100, 100, 110, 90, 100},
            '{100, 100, 100, 110, 90, 100}};
    for (int i = 0; i < 5; i++) begin
      set_pos(tbl[i]);
      push_expected();
      run_scan(0, 0, o);
      e = sb_q.pop_front();
      n_total++;
      if (o !== e) $display("FAIL multi_contact[%0d]: got %h want %h", i, o, e);
      else n_pass++;
    end
  endtask

  task automatic test_boundary();
    res_t o, e;
    int   tbl[10][6];
    tbl = '{'{100, 100, 116, 100, 900, 900}, '{100, 100, 116, 101, 900, 900},
            '{100, 100, 100, 116, 900, 900}, '{100, 100, 84, 100, 900, 900},
            '{100, 100, 400, 400, 700, 700}, '{100, 100, 96, 100, 900, 900},
            '{100, 100, 400, 400, 700, 700}, '{100, 100, 95, 103, 900, 900},
            '{500, 500, 500, 500, 500, 500}, '{1023, 1023, 0, 0, 1010, 1023}};
    for (int i = 0; i < 10; i++) begin
      set_pos(tbl[i]);
      push_expected();
      run_scan(0, 0, o);
      e = sb_q.pop_front();
      n_total++;
      if (o !== e) $display("FAIL boundary[%0d]: got %h want %h", i, o, e);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    res_t o, e;
    int   p[6];
    p = '{200, 200, 210, 205, 900, 100};
    set_pos(p);
    push_expected();
    run_scan(0, 0, o);
    e = sb_q.pop_front();
    n_total++;
    if (o !== e) $display("FAIL reset_mid_pre: got %h want %h", o, e);
    else n_pass++;
    // Abort the next scan with a reset at cycle 5: busy stops, nothing is reported.
    e = '0;
    e.busy_cyc = 4'd5;
    m_contact = 3'b000;
    sb_q.push_back(e);
    run_scan(0, 5, o);
    e = sb_q.pop_front();
    n_total++;
    if (o !== e) $display("FAIL reset_mid_abort: got %h want %h", o, e);
    else n_pass++;
    push_expected();
    run_scan(0, 0, o);
    e = sb_q.pop_front();
    n_total++;
    if (o !== e) $display("FAIL reset_mid_post: got %h want %h", o, e);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    res_t o, e;
    int   p[6];
    p = '{100, 100, 400, 400, 700, 700};
    set_pos(p);
    push_expected();
    run_scan(0, 0, o);
    e = sb_q.pop_front();
    n_total++;
    if (o !== e) $display("FAIL back_to_back_clear: got %h want %h", o, e);
    else n_pass++;
    p = '{300, 300, 300, 300, 312, 290};
    set_pos(p);
    push_expected();
    run_scan(3, 0, o);
    e = sb_q.pop_front();
    n_total++;
    if (o !== e) $display("FAIL back_to_back_busy_start: got %h want %h", o, e);
    else n_pass++;
  endtask

  initial begin
    n_pass = 0;
    n_total = 0;
    m_contact = 3'b000;
    bus.scan_start = 1'b0;
    bus.x1 = '0;
    bus.y1 = '0;
    bus.x2 = '0;
    bus.y2 = '0;
    bus.x3 = '0;
    bus.y3 = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    test_reset();
    test_no_collision();
    test_single_pair();
    test_multi_contact();
    test_boundary();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
